// File: rtl/ysyx_25010008_axi_sram.sv
// AXI4 slave memory model: independent read and write engines with fixed response
// latency, INCR/FIXED bursts, byte strobes and DECERR/SLVERR reporting.
module ysyx_25010008_axi_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned WR_LATENCY  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast
);

    localparam int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    // transfer size is fixed by the 32-bit bus
    logic unused_size;
    assign unused_size = ^{awsize, arsize};

    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return (addr - ADDR_BASE) >> 2;
    endfunction

    function automatic logic in_range(input logic [31:0] addr);
        return (addr >= ADDR_BASE) && (word_idx(addr) < 32'(DEPTH_WORDS));
    endfunction

    r_state_t    r_state, r_state_nx;
    logic [3:0]  r_cnt, r_cnt_nx, r_id, r_id_nx;
    logic [31:0] r_addr, r_addr_nx, r_word;
    logic [7:0]  r_len, r_len_nx, r_beat, r_beat_nx;
    logic [1:0]  r_burst, r_burst_nx, r_resp;
    logic        r_present;

    always_comb begin
        r_state_nx = r_state;
        r_cnt_nx   = r_cnt;
        r_id_nx    = r_id;
        r_addr_nx  = r_addr;
        r_len_nx   = r_len;
        r_burst_nx = r_burst;
        r_beat_nx  = r_beat;
        r_present  = 1'b0;
        case (r_state)
            R_IDLE: if (arvalid && arready) begin
                r_id_nx    = arid;
                r_addr_nx  = araddr;
                r_len_nx   = arlen;
                r_burst_nx = arburst;
                r_beat_nx  = '0;
                if (RD_LATENCY == 0) begin
                    r_state_nx = R_DATA;
                    r_present  = 1'b1;
                end else begin
                    r_state_nx = R_WAIT;
                    r_cnt_nx   = 4'(RD_LATENCY - 1);
                end
            end
            R_WAIT: if (r_cnt == 4'd0) begin
                r_state_nx = R_DATA;
                r_present  = 1'b1;
            end else begin
                r_cnt_nx = r_cnt - 4'd1;
            end
            R_DATA: if (rready) begin
                if (rlast) begin
                    r_state_nx = R_IDLE;
                end else begin
                    r_beat_nx = r_beat + 8'd1;
                    if (r_burst == BURST_INCR) r_addr_nx = r_addr + 32'd4;
                    r_present = 1'b1;
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // payload of the beat about to be presented; sampled before any same-edge write
    always_comb begin
        r_word = '0;
        r_resp = RESP_OKAY;
        if (!in_range(r_addr_nx))  r_resp = RESP_DECERR;
        else if (r_burst_nx[1])    r_resp = RESP_SLVERR;
        else                       r_word = mem[IDX_W'(word_idx(r_addr_nx))];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            rlast   <= 1'b0;
        end else begin
            r_state <= r_state_nx;
            r_cnt   <= r_cnt_nx;
            r_id    <= r_id_nx;
            r_addr  <= r_addr_nx;
            r_len   <= r_len_nx;
            r_burst <= r_burst_nx;
            r_beat  <= r_beat_nx;
            arready <= (r_state_nx == R_IDLE);
            rvalid  <= (r_state_nx == R_DATA);
            if (r_present) begin
                rid   <= r_id_nx;
                rdata <= r_word;
                rresp <= r_resp;
                rlast <= (r_beat_nx == r_len_nx);
            end
        end
    end

    w_state_t    w_state, w_state_nx;
    logic [3:0]  w_cnt, w_cnt_nx, w_id, w_id_nx;
    logic [31:0] w_addr, w_addr_nx;
    logic [7:0]  w_len, w_len_nx;
    logic [8:0]  w_beat, w_beat_nx;
    logic [1:0]  w_burst, w_burst_nx;
    logic        w_dec, w_dec_nx, w_slv, w_slv_nx, mem_we, b_load;

    always_comb begin
        w_state_nx = w_state;
        w_cnt_nx   = w_cnt;
        w_id_nx    = w_id;
        w_addr_nx  = w_addr;
        w_len_nx   = w_len;
        w_burst_nx = w_burst;
        w_beat_nx  = w_beat;
        w_dec_nx   = w_dec;
        w_slv_nx   = w_slv;
        mem_we     = 1'b0;
        b_load     = 1'b0;
        case (w_state)
            W_IDLE: if (awvalid && awready) begin
                w_id_nx    = awid;
                w_addr_nx  = awaddr;
                w_len_nx   = awlen;
                w_burst_nx = awburst;
                w_beat_nx  = '0;
                w_dec_nx   = 1'b0;
                w_slv_nx   = 1'b0;
                w_state_nx = W_DATA;
            end
            W_DATA: if (wvalid && wready) begin
                // beats past awlen are swallowed without touching the array
                if (w_beat <= {1'b0, w_len}) begin
                    if (!in_range(w_addr)) w_dec_nx = 1'b1;
                    if (w_burst[1])        w_slv_nx = 1'b1;
                    mem_we = in_range(w_addr) && !w_burst[1];
                    if (w_burst == BURST_INCR) w_addr_nx = w_addr + 32'd4;
                end
                if (w_beat != 9'd256) w_beat_nx = w_beat + 9'd1;
                if (wlast) begin
                    if (w_beat != {1'b0, w_len}) w_slv_nx = 1'b1;
                    b_load = 1'b1;
                    if (WR_LATENCY == 0) begin
                        w_state_nx = W_RESP;
                    end else begin
                        w_state_nx = W_WAIT;
                        w_cnt_nx   = 4'(WR_LATENCY - 1);
                    end
                end
            end
            W_WAIT: if (w_cnt == 4'd0) w_state_nx = W_RESP;
                    else               w_cnt_nx   = w_cnt - 4'd1;
            W_RESP: if (bready) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_dec   <= 1'b0;
            w_slv   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
        end else begin
            w_state <= w_state_nx;
            w_cnt   <= w_cnt_nx;
            w_id    <= w_id_nx;
            w_addr  <= w_addr_nx;
            w_len   <= w_len_nx;
            w_burst <= w_burst_nx;
            w_beat  <= w_beat_nx;
            w_dec   <= w_dec_nx;
            w_slv   <= w_slv_nx;
            awready <= (w_state_nx == W_IDLE);
            wready  <= (w_state_nx == W_DATA);
            bvalid  <= (w_state_nx == W_RESP);
            if (b_load) begin
                bid   <= w_id;
                bresp <= w_dec_nx ? RESP_DECERR : (w_slv_nx ? RESP_SLVERR : RESP_OKAY);
            end
        end
    end

    // byte-lane writes; array is deliberately left out of reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[IDX_W'(word_idx(w_addr))][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_axi_sram.sv
// Self-checking bench for ysyx_25010008_axi_sram: directed scenarios plus randomized
// bursts checked against an associative-array memory model.
`timescale 1ns/1ps
module tb_ysyx_25010008_axi_sram;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          RDL   = 2;
    localparam int          WRL   = 1;
    localparam logic [1:0]  FIXED = 2'b00;
    localparam logic [1:0]  INCR  = 2'b01;
    localparam logic [1:0]  WRAP  = 2'b10;
    localparam int          LIMIT = 200;

    logic        clock = 1'b0;
    logic        reset;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  awid, wstrb, bid, arid, rid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, bresp, arburst, rresp;
    logic        arvalid, arready, rvalid, rready, rlast;

    ysyx_25010008_axi_sram #(
        .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LATENCY(RDL), .WR_LATENCY(WRL)
    ) dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl [int];
    logic [31:0] wr_data [256];
    logic [3:0]  wr_strb [256];
    logic [31:0] rd_data [300];
    logic [1:0]  rd_resp [300];
    logic        rd_last [300];
    logic [3:0]  rd_id   [300];
    int          rd_n;
    logic        rd_stable;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic in_rng(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                               input logic [1:0] burst, input int nbeats);
        logic dec = 1'b0;
        logic slv = (burst == WRAP) || (burst == 2'b11);
        logic [31:0] a, w;
        int k;
        for (int b = 0; b < nbeats && b <= len; b++) begin
            a = (burst == INCR) ? addr + 32'(4 * b) : addr;
            if (!in_rng(a)) dec = 1'b1;
            else if (!slv) begin
                k = int'((a - BASE) >> 2);
                w = mdl.exists(k) ? mdl[k] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (wr_strb[b][i]) w[8*i +: 8] = wr_data[b][8*i +: 8];
                mdl[k] = w;
            end
        end
        if (nbeats - 1 != len) slv = 1'b1;
        return dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endfunction

    task automatic model_read(input logic [31:0] addr, input logic [1:0] burst, input int beat,
                              output logic [31:0] d, output logic [1:0] r);
        logic [31:0] a = (burst == INCR) ? addr + 32'(4 * beat) : addr;
        d = 32'h0;
        if (!in_rng(a))       r = 2'b11;
        else if (burst[1])    r = 2'b10;
        else begin
            r = 2'b00;
            d = mdl.exists(int'((a - BASE) >> 2)) ? mdl[int'((a - BASE) >> 2)] : 32'hx;
        end
    endtask

    // ---------------- bus drivers ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] id, input int nbeats, output logic [1:0] resp,
                             output logic [3:0] rbid, output int lat, output int aw_edge);
        int n;
        resp = 2'bxx; rbid = 4'hx; lat = -1; aw_edge = -1;
        awvalid = 1'b1; awaddr = addr; awlen = len; awburst = burst; awid = id; awsize = 3'd2;
        n = 0;
        while (awready !== 1'b1 && n < LIMIT) begin tick(); n++; end
        if (n >= LIMIT) begin
            n_checks++; n_fail++; awvalid = 1'b0;
            $display("FAIL aw_handshake: no awready after %0d cycles, required within %0d", n, LIMIT);
            return;
        end
        tick();
        aw_edge = int'(cyc);
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wvalid = 1'b1; wdata = wr_data[b]; wstrb = wr_strb[b]; wlast = (b == nbeats - 1);
            n = 0;
            while (wready !== 1'b1 && n < LIMIT) begin tick(); n++; end
            if (n >= LIMIT) begin
                n_checks++; n_fail++; wvalid = 1'b0;
                $display("FAIL w_handshake: no wready after %0d cycles, required within %0d", n, LIMIT);
                return;
            end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (bvalid !== 1'b1 && n < LIMIT) begin tick(); n++; end
        if (n >= LIMIT) begin
            n_checks++; n_fail++; bready = 1'b0;
            $display("FAIL b_handshake: no bvalid after %0d cycles, required within %0d", n, LIMIT);
            return;
        end
        lat = n; resp = bresp; rbid = bid;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input logic toggle, output int lat, output int ar_edge);
        int n;
        logic phase, done;
        logic [38:0] cap;
        rd_n = 0; rd_stable = 1'b1; lat = -1; ar_edge = -1;
        arvalid = 1'b1; araddr = addr; arlen = len; arburst = burst; arid = id; arsize = 3'd2;
        n = 0;
        while (arready !== 1'b1 && n < LIMIT) begin tick(); n++; end
        if (n >= LIMIT) begin
            n_checks++; n_fail++; arvalid = 1'b0;
            $display("FAIL ar_handshake: no arready after %0d cycles, required within %0d", n, LIMIT);
            return;
        end
        tick();
        ar_edge = int'(cyc);
        arvalid = 1'b0;
        n = 0;
        while (rvalid !== 1'b1 && n < LIMIT) begin tick(); n++; end
        lat = n;
        phase = 1'b1; done = 1'b0; n = 0;
        while (!done && n < 1000) begin
            rready = toggle ? phase : 1'b1;
            if (rvalid === 1'b1) begin
                cap = {rdata, rresp, rlast, rid};
                if (rready && rd_n < 300) begin
                    rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp;
                    rd_last[rd_n] = rlast; rd_id[rd_n] = rid;
                    rd_n++;
                end
                if (rready && rlast) done = 1'b1;
                tick();
                if (!rready && ({rdata, rresp, rlast, rid} !== cap || rvalid !== 1'b1)) rd_stable = 1'b0;
            end else begin
                tick();
            end
            phase = ~phase;
            n++;
        end
        rready = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL r_burst_end: no accepted rlast after %0d cycles, required within 1000", n);
        end
    endtask

    // checks every beat of the last read against the model
    task automatic check_read_beats(input string tag, input logic [31:0] addr, input int len,
                                    input logic [1:0] burst, input logic [3:0] id);
        logic [31:0] ed;
        logic [1:0]  er;
        n_checks++;
        if (rd_n != len + 1) begin
            n_fail++; $display("FAIL %s_beats: got %0d beats, expected %0d", tag, rd_n, len + 1);
        end
        for (int b = 0; b < rd_n && b <= len; b++) begin
            model_read(addr, burst, b, ed, er);
            n_checks++;
            if ({rd_data[b], rd_resp[b], rd_last[b], rd_id[b]} !== {ed, er, (b == len), id}) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got data %h resp %b last %b id %h, expected %h %b %b %h",
                         tag, b, rd_data[b], rd_resp[b], rd_last[b], rd_id[b], ed, er, (b == len), id);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wlast = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        reset = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            n_fail++; $display("FAIL reset_valids: got %b, expected 000000",
                               {awready, wready, bvalid, arready, rvalid, rlast});
        end
        n_checks++;
        if ({bid, rid, bresp, rresp, rdata} !== 44'h0) begin
            n_fail++; $display("FAIL reset_payload: got %h, expected 0", {bid, rid, bresp, rresp, rdata});
        end
        wvalid = 1'b1;
        @(negedge clock) reset = 1'b0;
        tick();
        n_checks++;
        if ({awready, arready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_release_ready: got %b, expected 11", {awready, arready});
        end
        tick();
        n_checks++;
        if (wready !== 1'b0) begin
            n_fail++; $display("FAIL w_before_aw: got wready %b, expected 0", wready);
        end
        wvalid = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] r, er; logic [3:0] i; int lat, e;
        wr_data[0] = 32'hDEAD_BEEF; wr_strb[0] = 4'hF;
        axi_write(32'h8000_0010, 8'd0, INCR, 4'h3, 1, r, i, lat, e);
        er = model_write(32'h8000_0010, 0, INCR, 1);
        n_checks++;
        if ({r, i} !== {er, 4'h3}) begin
            n_fail++; $display("FAIL single_bresp: got resp %b id %h, expected %b 3", r, i, er);
        end
        n_checks++;
        if (lat != WRL) begin n_fail++; $display("FAIL single_bvalid_latency: got %0d, expected %0d", lat, WRL); end
        axi_read(32'h8000_0010, 8'd0, INCR, 4'h6, 1'b0, lat, e);
        n_checks++;
        if (lat != RDL) begin n_fail++; $display("FAIL single_rvalid_latency: got %0d, expected %0d", lat, RDL); end
        check_read_beats("single", 32'h8000_0010, 0, INCR, 4'h6);
    endtask

    task automatic test_strobe();
        logic [1:0] r, er; logic [3:0] i; int lat, e;
        wr_data[0] = 32'h1122_3344; wr_strb[0] = 4'hF;
        axi_write(BASE, 8'd0, INCR, 4'h1, 1, r, i, lat, e);
        er = model_write(BASE, 0, INCR, 1);
        wr_data[0] = 32'hAABB_CCDD; wr_strb[0] = 4'b0101;
        axi_write(BASE, 8'd0, INCR, 4'h1, 1, r, i, lat, e);
        er = model_write(BASE, 0, INCR, 1);
        n_checks++;
        if (r !== er) begin n_fail++; $display("FAIL strobe_bresp: got %b, expected %b", r, er); end
        axi_read(BASE, 8'd0, INCR, 4'h2, 1'b0, lat, e);
        check_read_beats("strobe", BASE, 0, INCR, 4'h2);
    endtask

    task automatic test_incr_stall();
        logic [1:0] r, er; logic [3:0] i; int lat, e;
        for (int b = 0; b < 4; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
        axi_write(32'h8000_0100, 8'd3, INCR, 4'h4, 4, r, i, lat, e);
        er = model_write(32'h8000_0100, 3, INCR, 4);
        n_checks++;
        if (r !== er) begin n_fail++; $display("FAIL incr_wr_bresp: got %b, expected %b", r, er); end
        axi_read(32'h8000_0100, 8'd3, INCR, 4'h5, 1'b1, lat, e);
        check_read_beats("incr_stall", 32'h8000_0100, 3, INCR, 4'h5);
        n_checks++;
        if (rd_stable !== 1'b1) begin n_fail++; $display("FAIL incr_stall_hold: payload changed during stall, expected held"); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] r, er; logic [3:0] i; int lat, e;
        axi_read(32'h7FFF_FFFC, 8'd0, INCR, 4'h7, 1'b0, lat, e);
        check_read_beats("oor_read", 32'h7FFF_FFFC, 0, INCR, 4'h7);
        wr_data[0] = 32'hCAFE_F00D; wr_strb[0] = 4'hF;
        axi_write(32'h8000_4000, 8'd0, INCR, 4'h8, 1, r, i, lat, e);
        er = model_write(32'h8000_4000, 0, INCR, 1);
        n_checks++;
        if (r !== er) begin n_fail++; $display("FAIL oor_bresp: got %b, expected %b", r, er); end
        axi_read(BASE, 8'd0, INCR, 4'h9, 1'b0, lat, e);
        check_read_beats("oor_no_alias", BASE, 0, INCR, 4'h9);
    endtask

    task automatic test_protocol_error();
        logic [1:0] r, er; logic [3:0] i; int lat, e;
        wr_data[0] = 32'h0BAD_0BAD; wr_strb[0] = 4'hF;
        axi_write(32'h8000_0020, 8'd1, INCR, 4'hB, 1, r, i, lat, e);
        er = model_write(32'h8000_0020, 1, INCR, 1);
        n_checks++;
        if ({r, i} !== {er, 4'hB}) begin n_fail++; $display("FAIL short_burst_bresp: got %b id %h, expected %b B", r, i, er); end
        axi_read(32'h8000_0010, 8'd2, WRAP, 4'hC, 1'b0, lat, e);
        check_read_beats("wrap_read", 32'h8000_0010, 2, WRAP, 4'hC);
    endtask

    task automatic test_concurrent();
        logic [1:0] r, er; logic [3:0] i; int wl, rl, we, re;
        wr_data[0] = $urandom; wr_strb[0] = 4'hF;
        axi_write(32'h8000_0030, 8'd0, INCR, 4'h1, 1, r, i, wl, we);
        er = model_write(32'h8000_0030, 0, INCR, 1);
        wr_data[0] = $urandom; wr_data[1] = $urandom; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        fork
            axi_write(32'h8000_0034, 8'd1, INCR, 4'hD, 2, r, i, wl, we);
            axi_read(32'h8000_0030, 8'd0, INCR, 4'hE, 1'b0, rl, re);
        join
        er = model_write(32'h8000_0034, 1, INCR, 2);
        n_checks++;
        if (we != re) begin n_fail++; $display("FAIL concurrent_accept_edge: aw edge %0d, ar edge %0d, expected equal", we, re); end
        n_checks++;
        if ({r, i} !== {er, 4'hD}) begin n_fail++; $display("FAIL concurrent_bresp: got %b id %h, expected %b D", r, i, er); end
        check_read_beats("concurrent", 32'h8000_0030, 0, INCR, 4'hE);
        axi_read(32'h8000_0034, 8'd1, INCR, 4'hF, 1'b0, rl, re);
        check_read_beats("concurrent_wr", 32'h8000_0034, 1, INCR, 4'hF);
    endtask

    task automatic test_reset_mid();
        int n, lat, e;
        logic seen;
        arvalid = 1'b1; araddr = 32'h8000_0100; arlen = 8'd3; arburst = INCR; arid = 4'h9; arsize = 3'd2;
        n = 0;
        while (arready !== 1'b1 && n < LIMIT) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({rvalid, arready, awready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_async: got rvalid/arready/awready %b, expected 000", {rvalid, arready, awready});
        end
        tick(); tick();
        @(negedge clock) reset = 1'b0;
        tick();
        n_checks++;
        if (arready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_arready: got %b, expected 1", arready); end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (rvalid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid_rvalid: rvalid seen %b, expected 0", seen); end
        axi_read(32'h8000_0100, 8'd3, INCR, 4'hA, 1'b0, lat, e);
        check_read_beats("reset_mid_mem", 32'h8000_0100, 3, INCR, 4'hA);
    endtask

    task automatic test_random();
        logic [1:0] r, er, wb, rb; logic [3:0] i, id; int lat, e, len, nb, sel;
        logic [31:0] addr;
        for (int b = 0; b < 64; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
        axi_write(32'h8000_0200, 8'd63, INCR, 4'h0, 64, r, i, lat, e);
        er = model_write(32'h8000_0200, 63, INCR, 64);
        for (int b = 0; b < 8; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'hF; end
        axi_write(32'h8000_3FE0, 8'd7, INCR, 4'h0, 8, r, i, lat, e);
        er = model_write(32'h8000_3FE0, 7, INCR, 8);
        for (int t = 0; t < 24; t++) begin
            addr = ($urandom_range(0, 3) == 0) ? 32'h8000_3FE0 + 32'(4 * $urandom_range(0, 7))
                                               : 32'h8000_0200 + 32'(4 * $urandom_range(0, 56));
            len = int'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 11));
            wb  = (sel < 8) ? INCR : (sel < 11 ? FIXED : WRAP);
            nb  = (len > 0 && $urandom_range(0, 4) == 0) ? len : len + 1;
            id  = 4'($urandom);
            for (int b = 0; b < nb; b++) begin wr_data[b] = $urandom; wr_strb[b] = 4'($urandom); end
            axi_write(addr, 8'(len), wb, id, nb, r, i, lat, e);
            er = model_write(addr, len, wb, nb);
            n_checks++;
            if ({r, i} !== {er, id}) begin
                n_fail++; $display("FAIL rand%0d_bresp: got %b id %h, expected %b %h", t, r, i, er, id);
            end
            sel = int'($urandom_range(0, 9));
            rb  = (sel < 6) ? INCR : (sel < 9 ? FIXED : WRAP);
            id  = 4'($urandom);
            axi_read(addr, 8'(len), rb, id, 1'($urandom), lat, e);
            check_read_beats($sformatf("rand%0d", t), addr, len, rb, id);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_strobe();
        test_incr_stall();
        test_out_of_range();
        test_protocol_error();
        test_concurrent();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
